// File: rtl/umstr_reg_pkg.sv
// Shared definitions for the register-write arbiter: FSM encodings and an
// index-width helper.
package umstr_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    // Width of a port index; never less than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/umstr_rr_arbiter.sv
// Combinational round-robin select: first requester at or after ptr wins.
// The pointer register is owned by the caller.
module umstr_rr_arbiter
    import umstr_reg_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int IW      = idx_w(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               valid,
    output logic [N_PORTS-1:0] grant,
    output logic [IW-1:0]      idx
);

    // Scan from the farthest offset back to the pointer so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_PORTS]) begin
                valid = 1'b1;
                grant = '0;
                grant[(int'(ptr) + k) % N_PORTS] = 1'b1;
                idx   = IW'((int'(ptr) + k) % N_PORTS);
            end
        end
    end

endmodule

// File: rtl/umstr_reg_wr_arb.sv
// Round-robin arbiter sharing one register-write slave between N_PORTS
// requesters, with wait/ack routing and a timeout against a silent slave.
module umstr_reg_wr_arb
    import umstr_reg_pkg::*;
#(
    parameter int N_PORTS    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]    s_reg_wr_addr,
    input  logic [N_PORTS*DATA_WIDTH-1:0]    s_reg_wr_data,
    input  logic [N_PORTS*STRB_WIDTH-1:0]    s_reg_wr_strb,
    input  logic [N_PORTS-1:0]               s_reg_wr_en,
    output logic [N_PORTS-1:0]               s_reg_wr_wait,
    output logic [N_PORTS-1:0]               s_reg_wr_ack,
    output logic [ADDR_WIDTH-1:0]            m_reg_wr_addr,
    output logic [DATA_WIDTH-1:0]            m_reg_wr_data,
    output logic [STRB_WIDTH-1:0]            m_reg_wr_strb,
    output logic                             m_reg_wr_en,
    input  logic                             m_reg_wr_wait,
    input  logic                             m_reg_wr_ack,
    output logic [idx_w(N_PORTS)-1:0]        grant_idx,
    output logic                             timeout_pulse
);

    localparam int IW = idx_w(N_PORTS);
    localparam int TW = $clog2(TIMEOUT);

    arb_state_t          state_q, state_d;
    logic [IW-1:0]       ptr_q;
    logic [TW-1:0]       tmo_cnt;
    logic                arb_valid;
    logic [N_PORTS-1:0]  arb_grant;
    logic [IW-1:0]       arb_idx;
    logic                busy, en_g, tmo_hit, grant_now;

    umstr_rr_arbiter #(.N_PORTS(N_PORTS), .IW(IW)) u_arb (
        .req   (s_reg_wr_en),
        .ptr   (ptr_q),
        .valid (arb_valid),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign busy        = (state_q == ST_BUSY);
    assign en_g        = s_reg_wr_en[grant_idx];
    assign grant_now   = (state_q == ST_IDLE) && arb_valid;
    assign m_reg_wr_en = busy;

    // A requester that has already dropped en is an abort, not a timeout.
    assign tmo_hit       = busy && !m_reg_wr_ack && en_g && !m_reg_wr_wait && (tmo_cnt == '0);
    assign timeout_pulse = tmo_hit;

    always_comb begin
        s_reg_wr_wait = '0;
        s_reg_wr_ack  = '0;
        if (busy) begin
            s_reg_wr_wait            = s_reg_wr_en;
            s_reg_wr_wait[grant_idx] = m_reg_wr_wait;
            s_reg_wr_ack[grant_idx]  = m_reg_wr_ack || tmo_hit;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (arb_valid) state_d = ST_BUSY;
            ST_BUSY: if (m_reg_wr_ack || !en_g || tmo_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= '0;
            grant_idx     <= '0;
            tmo_cnt       <= TW'(TIMEOUT - 1);
            m_reg_wr_addr <= '0;
            m_reg_wr_data <= '0;
            m_reg_wr_strb <= '0;
        end else if (grant_now) begin
            grant_idx     <= arb_idx;
            ptr_q         <= (arb_idx == IW'(N_PORTS - 1)) ? '0 : arb_idx + 1'b1;
            tmo_cnt       <= TW'(TIMEOUT - 1);
            m_reg_wr_addr <= s_reg_wr_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
            m_reg_wr_data <= s_reg_wr_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
            m_reg_wr_strb <= s_reg_wr_strb[arb_idx*STRB_WIDTH +: STRB_WIDTH];
        end else if (busy && !m_reg_wr_wait && !m_reg_wr_ack && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_umstr_reg_wr_arb.sv
// Directed bench for umstr_reg_wr_arb: two ports, TIMEOUT=16.
module tb_umstr_reg_wr_arb;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*AW-1:0] s_addr;
    logic [N*DW-1:0] s_data;
    logic [N*SW-1:0] s_strb;
    logic [N-1:0]    s_en;
    logic [N-1:0]    s_wait, s_ack;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data;
    logic [SW-1:0]   m_strb;
    logic            m_en, m_wait, m_ack;
    logic [0:0]      gidx;
    logic            tp;

    int total = 0;
    int bad   = 0;

    umstr_reg_wr_arb #(
        .N_PORTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_reg_wr_addr (s_addr),
        .s_reg_wr_data (s_data),
        .s_reg_wr_strb (s_strb),
        .s_reg_wr_en   (s_en),
        .s_reg_wr_wait (s_wait),
        .s_reg_wr_ack  (s_ack),
        .m_reg_wr_addr (m_addr),
        .m_reg_wr_data (m_data),
        .m_reg_wr_strb (m_strb),
        .m_reg_wr_en   (m_en),
        .m_reg_wr_wait (m_wait),
        .m_reg_wr_ack  (m_ack),
        .grant_idx     (gidx),
        .timeout_pulse (tp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; s_addr = '0; s_data = '0; s_strb = '0; s_en = '0;
        m_wait = 1'b0; m_ack = 1'b0;
        #12;
        chk("rst_m_en",  m_en,   0);
        chk("rst_gidx",  gidx,   0);
        chk("rst_wait",  s_wait, 0);
        chk("rst_ack",   s_ack,  0);
        chk("rst_tp",    tp,     0);
        chk("rst_maddr", m_addr, 0);
        rst_n = 1'b1;

        // 1: single write from port 0, slave acks on the third BUSY cycle
        s_addr[0 +: AW] = 32'h10; s_data[0 +: DW] = 32'hDEADBEEF; s_strb[0 +: SW] = 4'hF;
        s_en = 2'b01;
        tick();
        chk("t1_m_en",  m_en,   1);
        chk("t1_addr",  m_addr, 32'h10);
        chk("t1_data",  m_data, 32'hDEADBEEF);
        chk("t1_strb",  m_strb, 4'hF);
        chk("t1_gidx",  gidx,   0);
        chk("t1_wait",  s_wait, 2'b00);
        chk("t1_noack", s_ack,  2'b00);
        tick();
        tick();
        m_ack = 1'b1; #1;
        chk("t1_ack",   s_ack,  2'b01);
        chk("t1_tp",    tp,     0);
        tick();
        m_ack = 1'b0; s_en = 2'b00;
        chk("t1_done_en",  m_en,  0);
        chk("t1_ack_once", s_ack, 2'b00);
        m_ack = 1'b1; #1;
        chk("t1_stray_ack", s_ack, 2'b00);
        m_ack = 1'b0;
        tick();

        // 2: both ports request out of reset; port 1 writes strb=0
        rst_n = 1'b0; #1; rst_n = 1'b1;
        s_addr[0 +: AW] = 32'h100; s_data[0 +: DW] = 32'h11111111; s_strb[0 +: SW] = 4'hF;
        s_addr[AW +: AW] = 32'h200; s_data[DW +: DW] = 32'h22222222; s_strb[SW +: SW] = 4'h0;
        s_en = 2'b11;
        tick();
        chk("t2_g0",     gidx,   0);
        chk("t2_addr0",  m_addr, 32'h100);
        chk("t2_wait1a", s_wait, 2'b10);
        tick();
        chk("t2_wait1b", s_wait, 2'b10);
        m_ack = 1'b1; #1;
        chk("t2_ack0",   s_ack,  2'b01);
        tick();
        m_ack = 1'b0; s_en = 2'b10;
        chk("t2_done",   m_en,   0);
        tick();
        s_en = 2'b11;
        tick();
        chk("t2_g1",     gidx,   1);
        chk("t2_addr1",  m_addr, 32'h200);
        chk("t2_data1",  m_data, 32'h22222222);
        chk("t2_strb0",  m_strb, 4'h0);
        chk("t2_wait0",  s_wait, 2'b01);
        m_ack = 1'b1; #1;
        chk("t2_ack1",   s_ack,  2'b10);
        tick();
        m_ack = 1'b0; s_en = 2'b01;
        tick();
        tick();
        chk("t2_g0_again", gidx, 0);
        chk("t2_en_again", m_en, 1);
        m_ack = 1'b1; #1;
        tick();
        m_ack = 1'b0; s_en = 2'b00;
        tick();

        // 3: long slave wait never times out
        m_wait = 1'b1; s_en = 2'b01;
        tick();
        for (int i = 0; i < 40; i++) begin
            chk("t3_wait_tp", {s_wait, tp}, {2'b01, 1'b0});
            tick();
        end
        m_wait = 1'b0; m_ack = 1'b1; #1;
        chk("t3_ack", s_ack, 2'b01);
        chk("t3_tp",  tp,    0);
        tick();
        m_ack = 1'b0; s_en = 2'b00;
        tick();

        // 4: silent slave, forced completion after 16 BUSY cycles
        s_en = 2'b10;
        tick();
        for (int i = 1; i <= 15; i++) begin
            chk("t4_busy", {m_en, tp, s_ack}, {1'b1, 1'b0, 2'b00});
            tick();
        end
        chk("t4_en16",  m_en,  1);
        chk("t4_tp",    tp,    1);
        chk("t4_ack",   s_ack, 2'b10);
        tick();
        chk("t4_en_off", m_en, 0);
        chk("t4_tp_off", tp,   0);
        s_en = 2'b00;
        tick();

        // 5: granted requester aborts; other port follows two cycles later
        s_en = 2'b11;
        tick();
        chk("t5_g0", gidx, 0);
        tick();
        s_en = 2'b10; #1;
        chk("t5_noack", s_ack, 2'b00);
        tick();
        chk("t5_en_off",  m_en, 0);
        tick();
        chk("t5_idle",    m_en, 0);
        tick();
        chk("t5_en_g1",   m_en, 1);
        chk("t5_g1",      gidx, 1);
        chk("t5_addr1",   m_addr, 32'h200);

        // 6: reset mid-BUSY clears outputs immediately, port 0 wins afterwards
        s_en = 2'b11;
        tick();
        chk("t6_pre_wait", s_wait, 2'b01);
        rst_n = 1'b0; #1;
        chk("t6_en",   m_en,   0);
        chk("t6_wait", s_wait, 0);
        chk("t6_ack",  s_ack,  0);
        chk("t6_gidx", gidx,   0);
        chk("t6_addr", m_addr, 0);
        rst_n = 1'b1;
        tick();
        chk("t6_regrant_en", m_en,   1);
        chk("t6_regrant_g",  gidx,   0);
        chk("t6_regrant_a",  m_addr, 32'h100);
        s_en = 2'b00;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
